c2f_scheduler: RTL
==================

# c2f_scheduler

Sequencer that runs one C2f block on a single shared convolution engine rather than on spatially unrolled convolutions. On `start` it issues, in order, the cv1 1x1 convolution, the two 3x3 convolutions of each of the N bottlenecks (no shortcut), and the final cv2 1x1 convolution. Each step is a command to the engine. The scheduler computes every operand address so that the concat is formed in place in a work buffer and never copied. It sits between the layer-level network controller and the conv engine/weight store.

## Interface
Parameters:
- `IN_CH`, 1: block input channels.
- `OUT_CH`, 1: block output channels.
- `MID_CH`, 1: hidden channels c; cv1 produces 2*MID_CH.
- `N`, 1: bottleneck count, legal 1..7.
- `MAP_WORDS`, 1: IN_H*IN_W, words per channel map.
- `ADDR_W`, 16: buffer address width.
- `CH_W`, 10: channel-count field width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: launch; sampled only in IDLE.
- `in_base`, `out_base`, `wrk_base`, in, ADDR_W each: source, destination and work-buffer bases, captured on an accepted `start`.
- `busy`, out, 1: high from the cycle after an accepted `start` through FINISH.
- `done`, out, 1: one-cycle pulse in FINISH.
- `cmd_valid`, out, 1: command valid.
- `cmd_ready`, in, 1: engine accepts the command.
- `cmd_src`, `cmd_dst`, out, ADDR_W each: operand base addresses.
- `cmd_in_ch`, `cmd_out_ch`, out, CH_W each: channel counts.
- `cmd_k`, out, 2: kernel size (1 or 3). Padding is k/2 and stride is 1, both implied.
- `cmd_wsel`, out, 4: weight/BN set index.
- `eng_done`, in, 1: engine completion pulse.

## Operation
Definitions:
- SLOT = MID_CH*MAP_WORDS. Slot k starts at wrk_base + k*SLOT.
- SCR (bottleneck scratch) = wrk_base + (2+N)*SLOT.
- All address arithmetic is mod 2^ADDR_W. Products are computed at full width, then truncated.

Op sequence, indexed by op_idx = 0..2N+1; `cmd_wsel` = op_idx:
- 0, cv1: src in_base, dst slot0 (writes slots 0 and 1, i.e. x1,x2), in IN_CH, out 2*MID_CH, k=1.
- 1+2i, bottleneck i cv1: src slot(1+i), dst SCR, in/out MID_CH, k=3.
- 2+2i, bottleneck i cv2: src SCR, dst slot(2+i), in/out MID_CH, k=3.
- 2N+1, cv2: src slot0, dst out_base, in (2+N)*MID_CH, out OUT_CH, k=1.

FSM states:
- IDLE: `start` leads to ISSUE with op_idx=0 and the bases latched.
- ISSUE: `cmd_valid`=1. When `cmd_valid`&&`cmd_ready`, go to WAIT.
- WAIT: on `eng_done`, if op_idx==2N+1 go to FINISH, else op_idx++ and go to ISSUE.
- FINISH: `done`=1, then IDLE.

Rules:
- `start` is ignored outside IDLE. The latched bases do not change mid-run.
- `eng_done` outside WAIT is ignored, including in the handshake cycle itself.
- `cmd_*` fields are registered. They are stable and valid throughout ISSUE and hold their last value otherwise.

## Timing
- Reset values: state IDLE, op_idx 0, `busy` 0, `done` 0, `cmd_valid` 0, all `cmd_*` fields 0.
- Accepted `start` at cycle t: `cmd_valid` and `busy` are 1 at t+1.
- Handshake at cycle h: `cmd_valid` is 0 at h+1.
- `eng_done` at cycle d (not last op): the next command is valid at d+1.
- `eng_done` at cycle d (last op): `done` is 1 at d+1 and `busy` is 0 at d+2.
- Minimum scheduler overhead is 2 cycles per op plus 1 cycle at start and 1 at finish.
- `cmd_valid` never drops without a handshake (AXI-style hold).
- `rst_n` low mid-run: immediate return to reset values. Any in-flight command is abandoned, and a later `eng_done` is ignored because the FSM is in IDLE.
- Back-to-back runs: `start` in the cycle after FINISH (the first IDLE cycle) is accepted.

## Configuration
- `C2F_SCHED_PERF_EN` defined: adds output `perf_cycles` [31:0].
  - Cleared on an accepted `start`.
  - Increments every cycle while `busy`, saturating at 0xFFFFFFFF.
  - Holds after `done`; reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- N=2, MID_CH=4, MAP_WORDS=16, IN_CH=8, OUT_CH=8, wrk_base=0x100, in_base=0x000, out_base=0x400, `cmd_ready` tied 1, `eng_done` 5 cycles after each handshake. Required: exactly 6 commands in this order.
  - (src,dst,in,out,k,wsel) = (0x000,0x100,8,8,1,0), (0x140,0x200,4,4,3,1), (0x200,0x180,4,4,3,2), (0x180,0x200,4,4,3,3), (0x200,0x1C0,4,4,3,4), (0x100,0x400,16,8,1,5).
  - One `done` pulse at the end.
- Backpressure: `cmd_ready` held low 7 cycles on op 2. Required: `cmd_valid` stays 1 and the fields are unchanged until the handshake; no duplicate issue.
- Spurious `eng_done` in ISSUE and `start` pulses while `busy`. Required: op_idx unaffected; no extra run; the total still has 2N+2 commands.
- `rst_n` asserted during WAIT of op 3, then `eng_done` pulsed. Required: `busy`=0, `cmd_valid`=0, no `done`. A new `start` begins again at op 0.
- Wrap-around: wrk_base=0xFFC0, SLOT=64, N=1. Required: slot2 dst=0x0040 and SCR=0x0080.
- PERF build with the run from test 1. Required: `perf_cycles` equals the number of cycles `busy` was high, and holds until the next `start`.

Source files
------------

// File: rtl/c2f_scheduler.sv
// c2f_scheduler: runs one C2f block (cv1, N bottlenecks, cv2) on a shared conv engine.
// Define C2F_SCHED_PERF_EN to add the saturating busy-cycle counter perf_cycles.
module c2f_scheduler #(
  parameter int IN_CH     = 1,
  parameter int OUT_CH    = 1,
  parameter int MID_CH    = 1,
  parameter int N         = 1,
  parameter int MAP_WORDS = 1,
  parameter int ADDR_W    = 16,
  parameter int CH_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [ADDR_W-1:0] wrk_base,
  output logic              busy,
  output logic              done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_src,
  output logic [ADDR_W-1:0] cmd_dst,
  output logic [CH_W-1:0]   cmd_in_ch,
  output logic [CH_W-1:0]   cmd_out_ch,
  output logic [1:0]        cmd_k,
  output logic [3:0]        cmd_wsel,
  input  logic              eng_done
`ifdef C2F_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam longint SLOT = longint'(MID_CH) * longint'(MAP_WORDS);
  localparam logic [3:0] LAST = 4'(2 * N + 1);
  localparam logic [CH_W-1:0] CH_IN   = CH_W'(IN_CH);
  localparam logic [CH_W-1:0] CH_OUT  = CH_W'(OUT_CH);
  localparam logic [CH_W-1:0] CH_MID  = CH_W'(MID_CH);
  localparam logic [CH_W-1:0] CH_2MID = CH_W'(2 * MID_CH);
  localparam logic [CH_W-1:0] CH_CAT  = CH_W'((2 + N) * MID_CH);

  function automatic logic [ADDR_W-1:0] slot_at(
    input logic [ADDR_W-1:0] base,
    input logic [3:0]        k
  );
    return base + ADDR_W'(64'(k) * 64'(SLOT));
  endfunction

  state_t            state;
  logic [3:0]        op_idx;
  logic [ADDR_W-1:0] in_q, out_q, wrk_q;

  logic [3:0]        nxt_op;
  logic [ADDR_W-1:0] b_in, b_out, b_wrk, scr;
  logic [ADDR_W-1:0] n_src, n_dst;
  logic [CH_W-1:0]   n_in, n_out;
  logic [1:0]        n_k;
  logic              load;

  // Operands of the next command come from the live inputs when launching
  always_comb begin
    if (state == IDLE) begin
      nxt_op = 4'd0;
      b_in   = in_base;
      b_out  = out_base;
      b_wrk  = wrk_base;
    end else begin
      nxt_op = op_idx + 4'd1;
      b_in   = in_q;
      b_out  = out_q;
      b_wrk  = wrk_q;
    end
    scr = slot_at(b_wrk, 4'(2 + N));
  end

  always_comb begin
    n_src = '0;
    n_dst = '0;
    n_in  = CH_MID;
    n_out = CH_MID;
    n_k   = 2'd3;
    unique case (1'b1)
      (nxt_op == 4'd0): begin
        n_src = b_in;
        n_dst = b_wrk;
        n_in  = CH_IN;
        n_out = CH_2MID;
        n_k   = 2'd1;
      end
      (nxt_op == LAST): begin
        n_src = b_wrk;
        n_dst = b_out;
        n_in  = CH_CAT;
        n_out = CH_OUT;
        n_k   = 2'd1;
      end
      (nxt_op[0] && nxt_op != LAST): begin
        n_src = slot_at(b_wrk, (nxt_op + 4'd1) >> 1);
        n_dst = scr;
      end
      default: begin
        n_src = scr;
        n_dst = slot_at(b_wrk, (nxt_op >> 1) + 4'd1);
      end
    endcase
  end

  assign load = (state == IDLE && start) ||
                (state == WAIT && eng_done && op_idx != LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_idx    <= 4'd0;
      in_q      <= '0;
      out_q     <= '0;
      wrk_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state     <= ISSUE;
          op_idx    <= 4'd0;
          in_q      <= in_base;
          out_q     <= out_base;
          wrk_q     <= wrk_base;
          busy      <= 1'b1;
          cmd_valid <= 1'b1;
        end
        ISSUE: if (cmd_ready) begin
          state     <= WAIT;
          cmd_valid <= 1'b0;
        end
        WAIT: if (eng_done) begin
          if (op_idx == LAST) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            op_idx    <= op_idx + 4'd1;
            state     <= ISSUE;
            cmd_valid <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_src    <= '0;
      cmd_dst    <= '0;
      cmd_in_ch  <= '0;
      cmd_out_ch <= '0;
      cmd_k      <= '0;
      cmd_wsel   <= '0;
    end else if (load) begin
      cmd_src    <= n_src;
      cmd_dst    <= n_dst;
      cmd_in_ch  <= n_in;
      cmd_out_ch <= n_out;
      cmd_k      <= n_k;
      cmd_wsel   <= nxt_op;
    end
  end

`ifdef C2F_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_cycles <= '0;
    else if (state == IDLE && start)
      perf_cycles <= '0;
    else if (busy && perf_cycles != 32'hFFFF_FFFF)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
